// File: rtl/fir_pkg.sv
// Shared constants, state encoding and power-on coefficients for the
// sequential 4-tap FIR controller.
package fir_pkg;

  localparam int DATA_W   = 8;
  localparam int NUM_TAPS = 4;
  localparam int ACC_W    = 18;
  localparam int TAP_W    = 2;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } fir_state_t;

  // Element [i] is the coefficient of tap i: c0..c3 = 1, 2, 3, 4.
  localparam logic [NUM_TAPS-1:0][DATA_W-1:0] DEFAULT_COEF =
    {8'd4, 8'd3, 8'd2, 8'd1};

endpackage

// File: rtl/fir_mac.sv
// Shared 8x8 multiplier feeding an 18-bit accumulator with synchronous clear
// and enable; one product is added per enabled cycle.
module fir_mac
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] prod;

  assign prod = a * b;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequential 4-tap FIR: accepts one sample, runs four MAC cycles through one
// shared multiplier, then holds the result until the consumer takes it.
module fir_seq_ctrl
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y,
  output logic              y_ovf,
  input  logic              coef_we,
  input  logic [TAP_W-1:0]  coef_addr,
  input  logic [DATA_W-1:0] coef_wdata,
  output logic              busy
);

  fir_state_t                         state;
  logic [TAP_W-1:0]                   tap;
  logic [DATA_W-1:0]                  x_reg, d0, d1, d2;
  logic [NUM_TAPS-1:0][DATA_W-1:0]    coef;
  logic [DATA_W-1:0]                  sample;
  logic [ACC_W-1:0]                   acc;
  logic                               accept;

  assign accept = in_valid & in_ready;

  always_comb begin
    sample = x_reg;
    unique case (tap)
      2'd0: sample = x_reg;
      2'd1: sample = d0;
      2'd2: sample = d1;
      2'd3: sample = d2;
      default: sample = x_reg;
    endcase
  end

  fir_mac u_mac (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .en    (state == MAC),
    .a     (sample),
    .b     (coef[tap]),
    .acc   (acc)
  );

  // Result is read straight from the accumulator, which is frozen outside MAC.
  assign y     = acc[DATA_W-1:0];
  assign y_ovf = |acc[ACC_W-1:DATA_W];

  // NOTE: the coefficient bank is four flops, not a RAM, so it is reset to
  // its defaults along with the rest of the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tap       <= '0;
      x_reg     <= '0;
      d0        <= '0;
      d1        <= '0;
      d2        <= '0;
      coef      <= DEFAULT_COEF;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (coef_we) coef[coef_addr] <= coef_wdata;
          if (accept) begin
            x_reg    <= x;
            tap      <= '0;
            state    <= MAC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        MAC: begin
          tap <= tap + 2'd1;
          if (tap == TAP_W'(NUM_TAPS - 1)) begin
            state     <= OUT;
            out_valid <= 1'b1;
            d0        <= x_reg;
            d1        <= d0;
            d2        <= d1;
          end
        end
        OUT: begin
          // in_ready rises only after the handshake edge, never alongside it.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Scoreboard bench for fir_seq_ctrl: a driver pushes expected results from a
// convolution model; a negedge monitor pops and compares on each handshake.
module tb_fir_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] x = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] y;
  logic       y_ovf;
  logic       coef_we = 1'b0;
  logic [1:0] coef_addr = '0;
  logic [7:0] coef_wdata = '0;
  logic       busy;

  fir_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (x),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y          (y),
    .y_ovf      (y_ovf),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] y;
    logic       ovf;
    int         acc_edge;
  } exp_t;

  exp_t        sb[$];
  int unsigned coef_m[4];
  int unsigned hist_m[3];

  task automatic model_reset();
    coef_m = '{1, 2, 3, 4};
    hist_m = '{0, 0, 0};
    sb.delete();
  endtask

  task automatic model_accept(input int unsigned v, input int at_edge);
    int unsigned full;
    exp_t e;
    full = v * coef_m[0] + hist_m[0] * coef_m[1] + hist_m[1] * coef_m[2] + hist_m[2] * coef_m[3];
    e.y = 8'(full % 256);
    e.ovf = (full >= 256);
    e.acc_edge = at_edge;
    sb.push_back(e);
    hist_m[2] = hist_m[1];
    hist_m[1] = hist_m[0];
    hist_m[0] = v;
  endtask

  // ---------------- monitor ----------------
  logic       pending = 1'b0;
  logic       prev_hold = 1'b0;
  logic [8:0] prev_val = '0;

  always @(negedge clk) begin
    if (reset) begin
      pending   = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_y", 32'({y_ovf, y}), 32'(prev_val));
      end
      if (out_valid && !pending) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          // Valid first seen after the 4th edge past accept (5th cycle).
          check("latency_edges", 32'(cyc - sb[0].acc_edge), 32'd4);
        end
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        check("y", 32'(y), 32'(sb[0].y));
        check("y_ovf", 32'(y_ovf), 32'(sb[0].ovf));
        void'(sb.pop_front());
      end
      pending   = out_valid && !out_ready;
      prev_hold = out_valid && !out_ready;
      prev_val  = {y_ovf, y};
    end
  end

  // ---------------- driver ----------------
  bit bp_random = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_random) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [7:0] v);
    wait_ready();
    if (!in_ready) return;
    x = v;
    in_valid = 1'b1;
    tick();
    model_accept(v, cyc);
    in_valid = 1'b0;
  endtask

  task automatic write_coef(input logic [1:0] a, input logic [7:0] d);
    wait_ready();
    coef_we = 1'b1;
    coef_addr = a;
    coef_wdata = d;
    tick();
    coef_we = 1'b0;
    coef_m[a] = d;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    tick();
    tick();
    reset = 1'b0;

    // Reset values.
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_y_ovf", 32'(y_ovf), 32'd0);

    // Impulse: 1,2,3,4,0.
    foreach (sb[i]) ;
    send(8'd1); send(8'd0); send(8'd0); send(8'd0); send(8'd0);
    drain();

    // Step: 10,30,60,100.
    repeat (4) send(8'd10);
    drain();

    // Overflow from clean history: FF/0, FD/1, FA/1, F6/1.
    do_reset();
    repeat (4) send(8'd255);
    drain();

    // Backpressure: hold in OUT for 3 cycles while in_valid pulses are dropped.
    out_ready = 1'b0;
    send(8'd7);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
    end
    check("bp_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      x = 8'd77;
      in_valid = 1'b1;
      tick();
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);

    // Coefficient write in IDLE, then impulse -> 1,2,3,0.
    do_reset();
    write_coef(2'd3, 8'd0);
    send(8'd1); send(8'd0); send(8'd0); send(8'd0);
    drain();

    // Write during MAC is ignored; following impulse still gives y=1.
    send(8'd0);
    tick();
    coef_we = 1'b1;
    coef_addr = 2'd0;
    coef_wdata = 8'd9;
    tick();
    tick();
    coef_we = 1'b0;
    drain();
    send(8'd1);
    drain();

    // Reset during the 2nd MAC cycle aborts without output or history shift.
    do_reset();
    send(8'd200);
    tick();
    reset = 1'b1;
    tick();
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    model_reset();
    send(8'd1); send(8'd0); send(8'd0); send(8'd0);
    drain();

    // Randomised traffic with random backpressure and idle coefficient writes.
    bp_random = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0)
        write_coef(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      send(8'($urandom_range(0, 255)));
    end
    bp_random = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 SHALL have exactly one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-002 SHALL have in_valid  input  1  sample offered.
REQ-003 SHALL have in_ready  output  1  controller can accept a sample.
REQ-004 SHALL have x  input  8  unsigned input sample.
REQ-005 SHALL have out_valid  output  1  result available.
REQ-006 SHALL have out_ready  input  1  consumer accepts result.
REQ-007 SHALL have y  output  8  filter result, low byte of accumulator.
REQ-008 SHALL have y_ovf  output  1  accumulator bits [17:8] nonzero.
REQ-009 SHALL have coef_we  input  1  coefficient write strobe.
REQ-010 SHALL have coef_addr  input  2  tap index 0..3.
REQ-011 SHALL have coef_wdata  input  8  unsigned coefficient value.
REQ-012 SHALL have busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL compute y_full = x*c0 + d0*c1 + d1*c2 + d2*c3, where d0..d2 are the previous three accepted samples (d0 most recent), using one shared 8x8 multiplier time-multiplexed over 4 taps.
REQ-014 SHALL implement states IDLE, MAC, OUT; IDLE -> MAC on in_valid & in_ready; MAC -> OUT after tap counter reaches 3; OUT -> IDLE on out_valid & out_ready.
REQ-015 SHALL drive in_ready = 1 only in IDLE; on accept it SHALL capture x into x_reg, clear the 18-bit accumulator, and set tap = 0.
REQ-016 SHALL, in MAC, add sample(tap)*coef[tap] per cycle (sample(0)=x_reg, 1=d0, 2=d1, 3=d2), incrementing tap 0,1,2,3; exactly 4 MAC cycles.
REQ-017 SHALL, on the MAC -> OUT transition, shift history: d0 <= x_reg, d1 <= d0, d2 <= d1.
REQ-018 SHALL assert out_valid in the 5th cycle after the accept edge (accept at edge T, MAC at edges T+1..T+4, out_valid high after edge T+4) and hold y, y_ovf, and out_valid stable until out_ready is sampled high.
REQ-019 SHALL give minimum throughput of one sample per 6 cycles; in_ready SHALL rise the cycle after the output handshake, never in the same cycle.
REQ-020 SHALL accumulate in 18 bits without saturation; y = acc[7:0] (modulo 256); y_ovf = |acc[17:8].
REQ-021 SHALL apply coef_we writes only in IDLE and SHALL silently ignore them in MAC and OUT.
REQ-022 SHALL ignore in_valid while in_ready is low, with no effect on history.

Reset
REQ-023 SHALL, on reset, set state IDLE, tap 0, x_reg, d0..d2, and accumulator to 0, and coefficients to c0..c3 = 1,2,3,4.
REQ-024 SHALL reset output values as follows: in_ready 1, out_valid 0, busy 0, y 0, y_ovf 0.
REQ-025 SHALL abort any in-flight operation on reset asserted in MAC or OUT, with no output produced and no history shift.

Structure
REQ-026 SHALL place the following in shared package fir_pkg: DATA_W=8, NUM_TAPS=4, ACC_W=18, state enum fir_state_t, and default coefficient array.
REQ-027 SHALL contain one sub-module, fir_mac (8x8 multiply, 18-bit accumulate with clear and enable); state, tap counter, history, and coefficient registers SHALL reside in fir_seq_ctrl.

Verification
REQ-028 SHALL be verified with an impulse test: x = 1, 0, 0, 0, 0 with out_ready = 1 -> y = 1, 2, 3, 4, 0, with y_ovf = 0 throughout.
REQ-029 SHALL be verified with a step test: x = 10 x4 -> y = 10, 30, 60, 100; out_valid appears exactly 5 cycles after each accept.
REQ-030 SHALL be verified with an overflow test: x = 255 x4 -> y = 0xFF/0, 0xFD/1, 0xFA/1, 0xF6/1 (y/y_ovf).
REQ-031 SHALL be verified with a backpressure test: out_ready = 0 for 3 cycles in OUT -> y stable, in_ready = 0, busy = 1, and in_valid pulses dropped.
REQ-032 SHALL be verified with a coefficient-write test: coef[3] = 0 written in IDLE, then impulse -> 1, 2, 3, 0; a write to coef[0] = 9 during MAC is ignored and the next impulse yields y = 1.
REQ-033 SHALL be verified with a reset-mid-MAC test: reset at the 2nd MAC cycle -> next cycle IDLE, in_ready = 1, out_valid = 0, and a subsequent impulse yields 1, 2, 3, 4.
